// File: rtl/lc4_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : lc4_mul_seq (with helper adder cla16)
// Purpose  : Iterative 16-bit shift-and-add multiplier for the LC4 MUL
//            instruction. A single cla16 adder is reused once per cycle.
//            The result is the low 16 bits of i_a * i_b. Because only the
//            low half is kept, signed and unsigned operands give the same
//            result.
// Ports    : clk        rising-edge clock
//            rst_n      asynchronous active-low reset
//            i_valid    operands valid (accepted only while o_ready)
//            o_ready    block idle and able to take operands
//            i_a, i_b   multiplicand / multiplier (16 bit)
//            o_valid    o_product valid (DONE state)
//            i_ready    consumer takes the result
//            o_product  (i_a * i_b) mod 2^16
//            o_busy     iteration loop running
// Options  : LC4_MUL_EARLY_EXIT_EN - leave the loop as soon as the
//            remaining multiplier bits are all zero.
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// cla16: 16-bit carry-lookahead adder built from four 4-bit lookahead
// groups. The carries into groups 1..3 come from a second lookahead level.
// No carry out is produced, because the only user keeps the sum modulo 2^16.
// ----------------------------------------------------------------------------
module cla16 (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    input  logic        i_cin,
    output logic [15:0] o_sum
);

    logic [14:0] w_g;    // bit generate; bit 15 cannot feed any carry we use
    logic [15:0] w_p;    // bit propagate
    logic [15:0] w_c;    // carry into each bit
    logic [2:0]  w_gg;   // group generate for groups 0..2
    logic [2:0]  w_gp;   // group propagate for groups 0..2

    assign w_g = i_a[14:0] & i_b[14:0];
    assign w_p = i_a ^ i_b;

    // Group generate/propagate feed the second lookahead level.
    for (genvar j = 0; j < 3; j++) begin : g_grp_gp
        assign w_gg[j] = w_g[4*j+3]
                       | (w_p[4*j+3] & w_g[4*j+2])
                       | (w_p[4*j+3] & w_p[4*j+2] & w_g[4*j+1])
                       | (w_p[4*j+3] & w_p[4*j+2] & w_p[4*j+1] & w_g[4*j]);
        assign w_gp[j] = &w_p[4*j+3:4*j];
    end

    // Second level: carries into each group, computed in parallel.
    assign w_c[0]  = i_cin;
    assign w_c[4]  = w_gg[0] | (w_gp[0] & i_cin);
    assign w_c[8]  = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & i_cin);
    assign w_c[12] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                   | (w_gp[2] & w_gp[1] & w_gp[0] & i_cin);

    // First level: carries inside each group from the group carry-in.
    for (genvar j = 0; j < 4; j++) begin : g_grp_carry
        assign w_c[4*j+1] = w_g[4*j] | (w_p[4*j] & w_c[4*j]);
        assign w_c[4*j+2] = w_g[4*j+1]
                          | (w_p[4*j+1] & w_g[4*j])
                          | (w_p[4*j+1] & w_p[4*j] & w_c[4*j]);
        assign w_c[4*j+3] = w_g[4*j+2]
                          | (w_p[4*j+2] & w_g[4*j+1])
                          | (w_p[4*j+2] & w_p[4*j+1] & w_g[4*j])
                          | (w_p[4*j+2] & w_p[4*j+1] & w_p[4*j] & w_c[4*j]);
    end

    assign o_sum = w_p ^ w_c;

endmodule

// ----------------------------------------------------------------------------
// lc4_mul_seq: control FSM and shift registers around one cla16.
// ----------------------------------------------------------------------------
module lc4_mul_seq #(
    parameter int ITERS = 16    // must equal the operand width
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [15:0] o_product,
    output logic        o_busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [4:0] c_last_cnt = 5'(ITERS - 1);

    state_t      r_state;
    state_t      w_state_next;

    logic [15:0] r_acc;
    logic [15:0] r_mcand;
    logic [15:0] r_mplier;
    logic [4:0]  r_cnt;

    logic [15:0] w_sum;
    logic [15:0] w_mplier_shr;
    logic        w_accept;
    logic        w_last;
    logic        w_finish;

    // The single shared adder: acc + shifted multiplicand.
    cla16 u_cla16 (
        .i_a   (r_acc),
        .i_b   (r_mcand),
        .i_cin (1'b0),
        .o_sum (w_sum)
    );

    assign w_mplier_shr = r_mplier >> 1;
    assign w_accept     = i_valid && (r_state == S_IDLE);
    assign w_last       = (r_cnt == c_last_cnt);

`ifdef LC4_MUL_EARLY_EXIT_EN
    // Once no multiplier bits remain above the current one, later
    // iterations could only add zero, so the loop can stop here.
    assign w_finish = w_last || (w_mplier_shr == 16'd0);
`else
    assign w_finish = w_last;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        o_ready      = 1'b0;
        o_valid      = 1'b0;
        o_busy       = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                o_busy = 1'b1;
                if (w_finish) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                o_valid = 1'b1;
                // Always return through IDLE: no accept on the result edge.
                if (i_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers. Operands are captured only on the accept edge.
    // In DONE and IDLE everything holds, so o_product stays stable while
    // the result waits for the consumer.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= 16'd0;
            r_mcand  <= 16'd0;
            r_mplier <= 16'd0;
            r_cnt    <= 5'd0;
        end else if (w_accept) begin
            r_acc    <= 16'd0;
            r_mcand  <= i_a;
            r_mplier <= i_b;
            r_cnt    <= 5'd0;
        end else if (r_state == S_RUN) begin
            if (r_mplier[0]) begin
                r_acc <= w_sum;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= w_mplier_shr;
            r_cnt    <= r_cnt + 5'd1;
        end
    end

    assign o_product = r_acc;

endmodule
`default_nettype wire
